// File: rtl/regfile_wb_buffer.sv
// 8 x 8-bit register file fed through a small write-back FIFO. Commits can be held off,
// and both combinational read ports forward uncommitted writes from the buffer.
module regfile_wb_buffer #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 3,
    parameter int DEPTH  = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       wr_valid,
    output logic                       wr_ready,
    input  logic [ADDR_W-1:0]          wr_addr,
    input  logic [DATA_W-1:0]          wr_data,
    input  logic                       hold,
    input  logic [ADDR_W-1:0]          rd_addr_a,
    output logic [DATA_W-1:0]          rd_data_a,
    input  logic [ADDR_W-1:0]          rd_addr_b,
    output logic [DATA_W-1:0]          rd_data_b,
    output logic [$clog2(DEPTH+1)-1:0] pending
);

    localparam int REGS  = 2 ** ADDR_W;
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);
    localparam logic [PTR_W:0]   DEPTH_X  = (PTR_W + 1)'(DEPTH);
    localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(DEPTH);

    logic [DATA_W-1:0] regs     [REGS];
    logic [ADDR_W-1:0] buf_addr [DEPTH];
    logic [DATA_W-1:0] buf_data [DEPTH];
    logic [PTR_W-1:0]  head;
    logic [PTR_W-1:0]  tail;
    logic [CNT_W-1:0]  count;
    logic              push;
    logic              commit;

    // Handshake: a request transfers on a rising edge where wr_valid and wr_ready are both 1;
    // wr_ready depends only on registered occupancy, and upstream holds the request until it transfers.
    assign wr_ready = (count < DEPTH_C);
    assign push     = wr_valid & wr_ready;
    assign commit   = (count != '0) & ~hold;
    assign pending  = count;

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        return (p == LAST_PTR) ? '0 : p + 1'b1;
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int r = 0; r < REGS; r++) begin
                regs[r] <= '0;
            end
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (push) begin
                tail <= next_ptr(tail);
            end
            if (commit) begin
                regs[buf_addr[head]] <= buf_data[head];
                head                 <= next_ptr(head);
            end
            if (push && !commit) begin
                count <= count + 1'b1;
            end else if (commit && !push) begin
                count <= count - 1'b1;
            end
        end
    end

    // Entry storage carries no reset: occupancy alone decides which slots are live.
    always_ff @(posedge clk) begin
        if (push) begin
            buf_addr[tail] <= wr_addr;
            buf_data[tail] <= wr_data;
        end
    end

    // Walk live entries oldest to newest so the newest match overrides older ones.
    always_comb begin
        logic [PTR_W:0] slot;
        rd_data_a = regs[rd_addr_a];
        rd_data_b = regs[rd_addr_b];
        for (int i = 0; i < DEPTH; i++) begin
            slot = {1'b0, head} + (PTR_W + 1)'(i);
            if (slot >= DEPTH_X) begin
                slot = slot - DEPTH_X;
            end
            if (CNT_W'(i) < count) begin
                if (buf_addr[slot[PTR_W-1:0]] == rd_addr_a) begin
                    rd_data_a = buf_data[slot[PTR_W-1:0]];
                end
                if (buf_addr[slot[PTR_W-1:0]] == rd_addr_b) begin
                    rd_data_b = buf_data[slot[PTR_W-1:0]];
                end
            end
        end
    end

endmodule

// File: tb/tb_regfile_wb_buffer.sv
// Directed, table-driven bench for regfile_wb_buffer: each row drives one cycle and checks
// the pre-edge outputs, followed by a hand-written drain sequence.
module tb_regfile_wb_buffer;

    logic       clk;
    logic       rst;
    logic       wr_valid;
    logic       wr_ready;
    logic [2:0] wr_addr;
    logic [7:0] wr_data;
    logic       hold;
    logic [2:0] rd_addr_a;
    logic [7:0] rd_data_a;
    logic [2:0] rd_addr_b;
    logic [7:0] rd_data_b;
    logic [1:0] pending;

    int n_checks = 0;
    int n_errors = 0;

    logic [7:0] exp_q[$];

    typedef struct {
        logic       rst;
        logic       v;
        logic [2:0] wa;
        logic [7:0] wd;
        logic       hold;
        logic [2:0] ra;
        logic [2:0] rb;
        logic       chk;
        logic [7:0] ea;
        logic [7:0] eb;
        logic [1:0] ep;
        logic       er;
    } vec_t;

    vec_t vecs[$];

    regfile_wb_buffer #(.DATA_W(8), .ADDR_W(3), .DEPTH(2)) dut (
        .clk       (clk),
        .rst       (rst),
        .wr_valid  (wr_valid),
        .wr_ready  (wr_ready),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .hold      (hold),
        .rd_addr_a (rd_addr_a),
        .rd_data_a (rd_data_a),
        .rd_addr_b (rd_addr_b),
        .rd_data_b (rd_data_b),
        .pending   (pending)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic add(input logic r, input logic v, input logic [2:0] wa, input logic [7:0] wd,
                       input logic h, input logic [2:0] ra, input logic [2:0] rb, input logic chk,
                       input logic [7:0] ea, input logic [7:0] eb, input logic [1:0] ep,
                       input logic er);
        vec_t t;
        t.rst = r; t.v = v; t.wa = wa; t.wd = wd; t.hold = h; t.ra = ra; t.rb = rb;
        t.chk = chk; t.ea = ea; t.eb = eb; t.ep = ep; t.er = er;
        vecs.push_back(t);
    endtask

    task automatic drive(input logic r, input logic v, input logic [2:0] wa, input logic [7:0] wd,
                         input logic h, input logic [2:0] ra, input logic [2:0] rb);
        rst = r; wr_valid = v; wr_addr = wa; wr_data = wd; hold = h;
        rd_addr_a = ra; rd_addr_b = rb;
    endtask

    initial begin
        int waited;
        drive(1'b1, 1'b0, 3'd0, 8'h00, 1'b0, 3'd0, 3'd0);

        //   rst v  wa    wd     hold ra    rb    chk  ea     eb     ep    er
        // reset with preloaded r3
        add(1, 0, 3'd0, 8'h00, 0, 3'd0, 3'd0, 0, 8'h00, 8'h00, 2'd0, 1);
        add(0, 1, 3'd3, 8'h5A, 0, 3'd3, 3'd0, 1, 8'h00, 8'h00, 2'd0, 1);
        add(0, 0, 3'd0, 8'h00, 0, 3'd3, 3'd0, 1, 8'h5A, 8'h00, 2'd1, 1);
        add(1, 0, 3'd0, 8'h00, 0, 3'd3, 3'd3, 1, 8'h5A, 8'h5A, 2'd0, 1);
        // basic push/forward/commit
        add(0, 1, 3'd3, 8'hA5, 0, 3'd3, 3'd3, 1, 8'h00, 8'h00, 2'd0, 1);
        add(0, 0, 3'd0, 8'h00, 0, 3'd3, 3'd3, 1, 8'hA5, 8'hA5, 2'd1, 1);
        add(0, 0, 3'd0, 8'h00, 0, 3'd3, 3'd0, 1, 8'hA5, 8'h00, 2'd0, 1);
        // full / backpressure
        add(0, 1, 3'd1, 8'h11, 1, 3'd1, 3'd2, 1, 8'h00, 8'h00, 2'd0, 1);
        add(0, 1, 3'd2, 8'h22, 1, 3'd1, 3'd2, 1, 8'h11, 8'h00, 2'd1, 1);
        add(0, 1, 3'd4, 8'h44, 1, 3'd1, 3'd2, 1, 8'h11, 8'h22, 2'd2, 0);
        add(0, 1, 3'd4, 8'h44, 1, 3'd4, 3'd2, 1, 8'h00, 8'h22, 2'd2, 0);
        add(0, 0, 3'd0, 8'h00, 0, 3'd1, 3'd2, 1, 8'h11, 8'h22, 2'd2, 0);
        add(0, 0, 3'd0, 8'h00, 0, 3'd1, 3'd2, 1, 8'h11, 8'h22, 2'd1, 1);
        add(0, 0, 3'd0, 8'h00, 0, 3'd4, 3'd2, 1, 8'h00, 8'h22, 2'd0, 1);
        // write-after-write to r5
        add(0, 1, 3'd5, 8'h10, 1, 3'd5, 3'd5, 1, 8'h00, 8'h00, 2'd0, 1);
        add(0, 1, 3'd5, 8'h20, 1, 3'd5, 3'd5, 1, 8'h10, 8'h10, 2'd1, 1);
        add(0, 0, 3'd0, 8'h00, 1, 3'd5, 3'd5, 1, 8'h20, 8'h20, 2'd2, 0);
        add(0, 0, 3'd0, 8'h00, 0, 3'd5, 3'd5, 1, 8'h20, 8'h20, 2'd2, 0);
        add(0, 0, 3'd0, 8'h00, 0, 3'd5, 3'd5, 1, 8'h20, 8'h20, 2'd1, 1);
        add(0, 0, 3'd0, 8'h00, 0, 3'd5, 3'd5, 1, 8'h20, 8'h20, 2'd0, 1);
        // simultaneous push and commit
        add(0, 1, 3'd6, 8'h61, 0, 3'd6, 3'd7, 1, 8'h00, 8'h00, 2'd0, 1);
        add(0, 1, 3'd7, 8'h72, 0, 3'd6, 3'd7, 1, 8'h61, 8'h00, 2'd1, 1);
        add(0, 1, 3'd6, 8'h63, 0, 3'd6, 3'd7, 1, 8'h61, 8'h72, 2'd1, 1);
        add(0, 0, 3'd0, 8'h00, 0, 3'd6, 3'd7, 1, 8'h63, 8'h72, 2'd1, 1);
        add(0, 0, 3'd0, 8'h00, 0, 3'd6, 3'd7, 1, 8'h63, 8'h72, 2'd0, 1);
        // reset with a full held buffer
        add(0, 1, 3'd0, 8'hAA, 1, 3'd0, 3'd1, 1, 8'h00, 8'h11, 2'd0, 1);
        add(0, 1, 3'd1, 8'hBB, 1, 3'd0, 3'd1, 1, 8'hAA, 8'h11, 2'd1, 1);
        add(1, 1, 3'd2, 8'hCC, 1, 3'd0, 3'd1, 1, 8'hAA, 8'hBB, 2'd2, 0);
        add(0, 0, 3'd0, 8'h00, 0, 3'd0, 3'd1, 1, 8'h00, 8'h00, 2'd0, 1);
        add(0, 0, 3'd0, 8'h00, 0, 3'd5, 3'd6, 1, 8'h00, 8'h00, 2'd0, 1);
        // reset outranks a commit in the same cycle
        add(0, 1, 3'd2, 8'hCC, 0, 3'd2, 3'd2, 1, 8'h00, 8'h00, 2'd0, 1);
        add(1, 0, 3'd0, 8'h00, 0, 3'd2, 3'd2, 1, 8'hCC, 8'hCC, 2'd1, 1);
        add(0, 0, 3'd0, 8'h00, 0, 3'd2, 3'd2, 1, 8'h00, 8'h00, 2'd0, 1);

        foreach (vecs[i]) begin
            @(negedge clk);
            drive(vecs[i].rst, vecs[i].v, vecs[i].wa, vecs[i].wd, vecs[i].hold,
                  vecs[i].ra, vecs[i].rb);
            #1;
            if (vecs[i].chk) begin
                check($sformatf("row%0d rd_data_a", i), 32'(rd_data_a), 32'(vecs[i].ea));
                check($sformatf("row%0d rd_data_b", i), 32'(rd_data_b), 32'(vecs[i].eb));
                check($sformatf("row%0d pending", i),   32'(pending),   32'(vecs[i].ep));
                check($sformatf("row%0d wr_ready", i),  32'(wr_ready),  32'(vecs[i].er));
            end
        end

        // Hand sequence: fill under hold, release, drain within a bounded number of cycles.
        @(negedge clk);
        drive(1'b0, 1'b1, 3'd3, 8'h33, 1'b1, 3'd0, 3'd0);
        exp_q.push_back(8'h33);
        @(negedge clk);
        drive(1'b0, 1'b1, 3'd4, 8'h44, 1'b1, 3'd0, 3'd0);
        exp_q.push_back(8'h44);
        @(negedge clk);
        drive(1'b0, 1'b0, 3'd0, 8'h00, 1'b1, 3'd3, 3'd4);
        #1;
        check("seq full pending", 32'(pending), 32'd2);
        check("seq full ready", 32'(wr_ready), 32'd0);
        @(negedge clk);
        hold = 1'b0;
        waited = 0;
        #1;
        while (pending !== 2'd0 && waited < 10) begin
            @(negedge clk);
            #1;
            waited++;
        end
        check("seq drain in time", 32'(waited < 10), 32'd1);
        check("seq drain cycles", 32'(waited), 32'd2);
        check("seq ready after drain", 32'(wr_ready), 32'd1);
        check("seq r3 committed", 32'(rd_data_a), 32'(exp_q.pop_front()));
        check("seq r4 committed", 32'(rd_data_b), 32'(exp_q.pop_front()));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
